// File: rtl/mw_add_seq_pkg.sv
// Shared definitions for the sequential multi-word adder: word width, FSM encoding
// and the signed-overflow rule applied to the top word.
package mw_add_seq_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  // Operands share a sign but the result sign differs -> two's complement overflow.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/cla32bit.sv
// 32-bit carry-lookahead adder: eight 4-bit lookahead groups with the group carries
// chained between groups.
module cla32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g_s;
  logic [31:0] p_s;
  logic [32:0] c_s;

  // Generate/propagate terms and per-group lookahead carries
  always_comb begin
    g_s    = a & b;
    p_s    = a ^ b;
    c_s    = 33'd0;
    c_s[0] = cin;
    for (int grp = 0; grp < 8; grp++) begin
      int bs;
      bs = grp * 4;
      c_s[bs+1] = g_s[bs] | (p_s[bs] & c_s[bs]);
      c_s[bs+2] = g_s[bs+1] | (p_s[bs+1] & g_s[bs])
                | (p_s[bs+1] & p_s[bs] & c_s[bs]);
      c_s[bs+3] = g_s[bs+2] | (p_s[bs+2] & g_s[bs+1])
                | (p_s[bs+2] & p_s[bs+1] & g_s[bs])
                | (p_s[bs+2] & p_s[bs+1] & p_s[bs] & c_s[bs]);
      c_s[bs+4] = g_s[bs+3] | (p_s[bs+3] & g_s[bs+2])
                | (p_s[bs+3] & p_s[bs+2] & g_s[bs+1])
                | (p_s[bs+3] & p_s[bs+2] & p_s[bs+1] & g_s[bs])
                | (p_s[bs+3] & p_s[bs+2] & p_s[bs+1] & p_s[bs] & c_s[bs]);
    end
    sum  = p_s ^ c_s[31:0];
    cout = c_s[32];
  end

endmodule

// File: rtl/mw_add_seq.sv
// Sequential WORDS*32-bit adder/subtractor: walks one word per cycle through a single
// cla32bit, carrying between words in a register; result offered on valid/ready.
module mw_add_seq
  import mw_add_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_W*WORDS-1:0]   a,
  input  logic [WORD_W*WORDS-1:0]   b,
  input  logic                      cin,
  input  logic                      sub,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W*WORDS-1:0]   sum,
  output logic                      cout,
  output logic                      ovf,
  output logic                      busy
);

  localparam int N     = WORD_W * WORDS;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(1'b0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);

  state_e state_r;
  state_e state_s;

  logic [IDX_W-1:0]             idx_r;
  logic                         carry_r;
  logic [WORDS-1:0][WORD_W-1:0] a_r;
  logic [WORDS-1:0][WORD_W-1:0] b_r;
  logic [WORDS-1:0][WORD_W-1:0] sum_r;
  logic                         cout_r;
  logic                         ovf_r;
  logic                         in_ready_r;
  logic                         out_valid_r;
  logic                         busy_r;

  logic                         accept_s;
  logic                         last_s;
  logic [WORD_W-1:0]            sum32_s;
  logic                         cout32_s;

  cla32bit u_cla (
    .a    (a_r[idx_r]),
    .b    (b_r[idx_r]),
    .cin  (carry_r),
    .sum  (sum32_s),
    .cout (cout32_s)
  );

  // Next-state decode; acceptance only happens from IDLE
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    last_s   = (idx_r == IDX_LAST);
    case (state_r)
      S_IDLE: begin
        if (in_valid) begin
          state_s  = S_RUN;
          accept_s = 1'b1;
        end else begin
          state_s  = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_s) begin
          state_s = S_DONE;
        end else begin
          state_s = S_RUN;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State register and status flags, registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == S_IDLE);
      out_valid_r <= (state_s == S_DONE);
      busy_r      <= (state_s != S_IDLE);
    end
  end

  // Operand staging and word-serial accumulation; B is pre-inverted for subtraction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r   <= IDX_ZERO;
      carry_r <= 1'b0;
      a_r     <= {N{1'b0}};
      b_r     <= {N{1'b0}};
      sum_r   <= {N{1'b0}};
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept_s) begin
      a_r     <= a;
      b_r     <= sub ? ~b : b;
      carry_r <= cin ^ sub;
      idx_r   <= IDX_ZERO;
    end else if (state_r == S_RUN) begin
      sum_r[idx_r] <= sum32_s;
      carry_r      <= cout32_s;
      if (last_s) begin
        cout_r <= cout32_s;
        ovf_r  <= add_ovf(a_r[WORDS-1][WORD_W-1], b_r[WORDS-1][WORD_W-1],
                          sum32_s[WORD_W-1]);
        idx_r  <= IDX_ZERO;
      end else begin
        idx_r  <= idx_r + IDX_ONE;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_mw_add_seq.sv
// Directed and randomised self-checking bench for mw_add_seq with WORDS=4 (128 bits).
module tb_mw_add_seq;

  localparam int WORDS = 4;
  localparam int N     = 128;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic         cin       = 1'b0;
  logic         sub       = 1'b0;
  logic [N-1:0] a         = {N{1'b0}};
  logic [N-1:0] b         = {N{1'b0}};
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  mw_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Expected {ovf, cout, sum}; subtraction borrows from an extra leading 1.
  function automatic logic [N+1:0] ref_model(input logic [N-1:0] ra, input logic [N-1:0] rb,
                                             input logic rc, input logic rs);
    logic [N:0] full;
    logic       o;
    if (!rs) begin
      full = {1'b0, ra} + {1'b0, rb} + {{N{1'b0}}, rc};
      o    = (ra[N-1] == rb[N-1]) && (full[N-1] != ra[N-1]);
    end else begin
      full = {1'b1, ra} - {1'b0, rb} - {{N{1'b0}}, rc};
      o    = (ra[N-1] != rb[N-1]) && (full[N-1] != ra[N-1]);
    end
    return {o, full[N], full[N-1:0]};
  endfunction

  function automatic logic [N-1:0] rand_op();
    logic [N-1:0] r;
    for (int w = 0; w < WORDS; w++)
      r[w*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
    return r;
  endfunction

  task automatic send_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tc,
                         input logic ts, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (sum !== {N{1'b0}}) begin failures++; $display("FAIL reset_sum got=%h exp=0", sum); end
    checks++; if ({cout, ovf} !== 2'b00) begin failures++; $display("FAIL reset_cout_ovf got=%b exp=00", {cout, ovf}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_ripple();
    int lat;
    send_op({N{1'b1}}, 128'd1, 1'b0, 1'b0, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL ripple_latency got=%0d exp=4", lat); end
    checks++; if (sum !== {N{1'b0}}) begin failures++; $display("FAIL ripple_sum got=%h exp=0", sum); end
    checks++; if ({cout, ovf} !== 2'b10) begin failures++; $display("FAIL ripple_cout_ovf got=%b exp=10", {cout, ovf}); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ripple_busy_done got=%b exp=1", busy); end
    take_result();
  endtask

  task automatic test_word_carry();
    int lat;
    send_op(128'h0000_0000_FFFF_FFFF, 128'd1, 1'b0, 1'b0, lat);
    checks++; if (sum !== 128'h1_0000_0000) begin failures++; $display("FAIL wcarry_sum got=%h exp=100000000", sum); end
    checks++; if ({cout, ovf} !== 2'b00) begin failures++; $display("FAIL wcarry_cout_ovf got=%b exp=00", {cout, ovf}); end
    take_result();
  endtask

  task automatic test_subtract();
    int lat;
    send_op(128'd5, 128'd7, 1'b0, 1'b1, lat);
    checks++; if (sum !== {{(N-2){1'b1}}, 2'b10}) begin failures++; $display("FAIL sub_neg_sum got=%h exp=ff..fe", sum); end
    checks++; if ({cout, ovf} !== 2'b00) begin failures++; $display("FAIL sub_neg_cout_ovf got=%b exp=00", {cout, ovf}); end
    take_result();
    send_op({1'b1, {(N-1){1'b0}}}, 128'd1, 1'b0, 1'b1, lat);
    checks++; if (sum !== {1'b0, {(N-1){1'b1}}}) begin failures++; $display("FAIL sub_ovf_sum got=%h exp=7f..ff", sum); end
    checks++; if ({cout, ovf} !== 2'b11) begin failures++; $display("FAIL sub_ovf_cout_ovf got=%b exp=11", {cout, ovf}); end
    take_result();
    send_op(128'd10, 128'd3, 1'b1, 1'b1, lat);
    checks++; if ({cout, ovf, sum} !== {2'b10, 128'd6}) begin failures++; $display("FAIL sub_borrowin got=%b_%h exp=10_6", {cout, ovf}, sum); end
    take_result();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [N-1:0] exp_sum;
    exp_sum = 128'h0000_0011_0000_0022_0000_0033_0000_0044;
    send_op(128'h0000_0001_0000_0002_0000_0003_0000_0004,
            128'h0000_0010_0000_0020_0000_0030_0000_0040, 1'b0, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      a = {N{1'b1}}; b = {N{1'b1}};
      @(posedge clk); #1;
      checks++; if ({out_valid, in_ready} !== 2'b10) begin failures++; $display("FAIL bp_hold_flags cyc=%0d got=%b exp=10", i, {out_valid, in_ready}); end
      checks++; if (sum !== exp_sum) begin failures++; $display("FAIL bp_hold_sum cyc=%0d got=%h exp=%h", i, sum, exp_sum); end
    end
    in_valid = 1'b0;
    take_result();
    checks++; if ({in_ready, busy, out_valid} !== 3'b100) begin failures++; $display("FAIL bp_after_flags got=%b exp=100", {in_ready, busy, out_valid}); end
    checks++; if (sum !== exp_sum) begin failures++; $display("FAIL bp_after_sum got=%h exp=%h", sum, exp_sum); end
  endtask

  task automatic test_back_to_back();
    logic [N+1:0] exp_q[$];
    logic [N+1:0] exp;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    while (got < 100 && cyc < 20000) begin
      if (sent < 100 && $urandom_range(0, 1) == 1) begin
        a = rand_op(); b = rand_op();
        cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(a, b, cin, sub));
        sent++;
      end
      if (out_valid && out_ready) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : {(N+2){1'bx}};
        checks++;
        if ({ovf, cout, sum} !== exp) begin
          failures++;
          $display("FAIL b2b_result n=%0d got=%b_%b_%h exp=%b_%b_%h", got, ovf, cout, sum,
                   exp[N+1], exp[N], exp[N-1:0]);
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (got !== 100) begin failures++; $display("FAIL b2b_count got=%0d exp=100", got); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL b2b_leftover got=%0d exp=0", exp_q.size()); end
    repeat (8) @(posedge clk);
    #1;
    checks++; if ({out_valid, busy} !== 2'b00) begin failures++; $display("FAIL b2b_idle got=%b exp=00", {out_valid, busy}); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    a = 128'h1234_5678_9ABC_DEF0_1111_2222_3333_4444; b = 128'd1; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if ({in_ready, out_valid, busy} !== 3'b100) begin failures++; $display("FAIL midrst_flags got=%b exp=100", {in_ready, out_valid, busy}); end
    checks++; if (sum !== {N{1'b0}}) begin failures++; $display("FAIL midrst_sum got=%h exp=0", sum); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_op(128'd3, 128'd4, 1'b1, 1'b0, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL postrst_latency got=%0d exp=4", lat); end
    checks++; if ({cout, ovf, sum} !== {2'b00, 128'd8}) begin failures++; $display("FAIL postrst_result got=%b_%h exp=00_8", {cout, ovf}, sum); end
    take_result();
  endtask

  initial begin
    test_reset();
    test_full_ripple();
    test_word_carry();
    test_subtract();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
